pwm_compare: RTL and testbench

//  Downstream consumer of the free-running counter: compares its count against a

---
 rtl/pwm_compare_if.sv | 20 ++
 rtl/pwm_compare.sv | 90 +++++++++
 tb/tb_pwm_compare.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_compare_if.sv
// Duty-load handshake between the duty source and pwm_compare.
interface pwm_compare_if #(
   parameter int WIDTH = 8
);
   logic             duty_valid;
   logic [WIDTH:0]   duty_data;
   logic             duty_ready;

   modport master (
      output duty_valid,
      output duty_data,
      input  duty_ready
   );

   modport slave (
      input  duty_valid,
      input  duty_data,
      output duty_ready
   );
endinterface

// File: rtl/pwm_compare.sv
// Period-aligned PWM comparator driven by an upstream free-running counter.
// Duty is double-buffered; loads and start/stop take effect at period boundaries.
module pwm_compare #(
   parameter int WIDTH      = 8,
   parameter int DUTY_RESET = 0,
   parameter bit INVERT     = 1'b0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             cnt_rollover,
   input  logic             cnt_enable,
   input  logic             pwm_en,
   pwm_compare_if.slave     duty,
   output logic             pwm_out,
   output logic             running,
   output logic             update_ack
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam logic [WIDTH:0] DUTY_RST = (WIDTH+1)'(DUTY_RESET);

   logic [1:0]     state;
   logic [1:0]     nxt;
   logic           en_q;
   logic           pending;
   logic [WIDTH:0] active;
   logic [WIDTH:0] shadow;
   logic [WIDTH:0] duty_eff;
   logic           boundary;
   logic           accept;
   logic           apply;
   logic           nxt_run;

   // A rollover held while the counter is stalled is not a new period.
   assign boundary = cnt_rollover & en_q;
   assign accept   = duty.duty_valid & ~pending;
   assign apply    = boundary & pending;
   assign duty_eff = apply ? shadow : active;
   assign nxt_run  = (nxt == S_RUN) | (nxt == S_DRAIN);

   assign duty.duty_ready = ~pending;

   always_comb begin
      nxt = state;
      unique case (state)
         S_IDLE:  if (pwm_en) nxt = S_ARMED;
         S_ARMED: begin
            if (!pwm_en)       nxt = S_IDLE;
            else if (boundary) nxt = S_RUN;
         end
         S_RUN:   if (!pwm_en) nxt = S_DRAIN;
         S_DRAIN: begin
            if (pwm_en)        nxt = S_RUN;
            else if (boundary) nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         en_q       <= 1'b0;
         pending    <= 1'b0;
         active     <= DUTY_RST;
         shadow     <= DUTY_RST;
         pwm_out    <= INVERT;
         running    <= 1'b0;
         update_ack <= 1'b0;
      end else begin
         state      <= nxt;
         en_q       <= cnt_enable;
         update_ack <= apply;
         running    <= nxt_run;
         pwm_out    <= INVERT ^ (nxt_run & ({1'b0, cnt_in} < duty_eff));
         if (accept) begin
            shadow  <= duty.duty_data;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
         if (apply) active <= shadow;
      end
   end

endmodule

// File: tb/tb_pwm_compare.sv
// Scoreboard bench for pwm_compare with a modelled 0..9 upstream counter.
module tb_pwm_compare;

   localparam int MAXC = 9;

   typedef struct packed {
      logic pwm;
      logic run;
      logic ack;
      logic rdy;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] cnt;
   logic       roll;
   logic       cen;
   logic       pwm_en;
   logic       pwm_out;
   logic       running;
   logic       update_ack;

   int   n_chk = 0;
   int   n_err = 0;
   exp_t sbq[$];

   int         m_state;
   int         m_act;
   int         m_shd;
   bit         m_pend;
   bit         m_enq;

   pwm_compare_if #(.WIDTH(8)) duty_if ();

   pwm_compare #(
      .WIDTH(8),
      .DUTY_RESET(0),
      .INVERT(1'b0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .cnt_in(cnt),
      .cnt_rollover(roll),
      .cnt_enable(cen),
      .pwm_en(pwm_en),
      .duty(duty_if),
      .pwm_out(pwm_out),
      .running(running),
      .update_ack(update_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_act   = 0;
      m_shd   = 0;
      m_pend  = 1'b0;
      m_enq   = 1'b0;
   endtask

   task automatic cnt_advance();
      if (cen) begin
         if (int'(cnt) == MAXC) begin
            cnt  = 8'd0;
            roll = 1'b1;
         end else begin
            cnt  = cnt + 8'd1;
            roll = 1'b0;
         end
      end
   endtask

   // One clock: predict, push, clock, update model, pop and compare.
   task automatic step();
      bit   bnd, acc, app, nrun;
      int   eff, ns;
      exp_t e, o;
      bnd = roll && m_enq;
      acc = duty_if.duty_valid && !m_pend;
      app = bnd && m_pend;
      eff = app ? m_shd : m_act;
      ns  = m_state;
      if (m_state == 0) ns = pwm_en ? 1 : 0;
      if (m_state == 1) ns = !pwm_en ? 0 : (bnd ? 2 : 1);
      if (m_state == 2) ns = pwm_en ? 2 : 3;
      if (m_state == 3) ns = pwm_en ? 2 : (bnd ? 0 : 3);
      nrun  = (ns == 2) || (ns == 3);
      e.pwm = nrun && (int'(cnt) < eff);
      e.run = nrun;
      e.ack = app;
      e.rdy = !(acc || (m_pend && !app));
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (app) m_act = m_shd;
      if (acc) begin
         m_shd  = int'(duty_if.duty_data);
         m_pend = 1'b1;
         duty_if.duty_valid = 1'b0;
      end else if (app) begin
         m_pend = 1'b0;
      end
      m_state = ns;
      m_enq   = cen;
      cnt_advance();
      o = sbq.pop_front();
      chk("pwm_out", int'(pwm_out), int'(o.pwm));
      chk("running", int'(running), int'(o.run));
      chk("update_ack", int'(update_ack), int'(o.ack));
      chk("duty_ready", int'(duty_if.duty_ready), int'(o.rdy));
   endtask

   // Advance until the current inputs present a fresh boundary (cnt=0).
   task automatic sync();
      int n;
      n = 0;
      while (!(cnt == 8'd0 && roll && cen) && n < 40) begin
         step();
         n++;
      end
      if (n >= 40) chk("sync_timeout", 0, 1);
   endtask

   task automatic run_period(input int k, input bit new_en,
                             input bit do_load, input int val,
                             output int hi, output int acks);
      hi   = 0;
      acks = 0;
      for (int i = 0; i <= MAXC; i++) begin
         if (i == k) begin
            pwm_en = new_en;
            if (do_load) begin
               duty_if.duty_valid = 1'b1;
               duty_if.duty_data  = 9'(val);
            end
         end
         step();
         hi   += int'(pwm_out);
         acks += int'(update_ack);
      end
   endtask

   initial begin
      int hi, ak;
      reset_n = 1'b0;
      cnt     = 8'd0;
      roll    = 1'b0;
      cen     = 1'b1;
      pwm_en  = 1'b0;
      duty_if.duty_valid = 1'b0;
      duty_if.duty_data  = 9'd0;
      model_reset();
      #1;
      chk("rst_pwm", int'(pwm_out), 0);
      chk("rst_running", int'(running), 0);
      chk("rst_ack", int'(update_ack), 0);
      chk("rst_ready", int'(duty_if.duty_ready), 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // start with duty 3
      pwm_en = 1'b1;
      duty_if.duty_valid = 1'b1;
      duty_if.duty_data  = 9'd3;
      sync();
      run_period(-1, 1'b1, 1'b0, 0, hi, ak);
      chk("duty3_hi", hi, 3);
      chk("duty3_ack", ak, 1);
      run_period(-1, 1'b1, 1'b0, 0, hi, ak);
      chk("duty3_hi2", hi, 3);

      // mid-period load of 7
      sync();
      run_period(3, 1'b1, 1'b1, 7, hi, ak);
      chk("load7_cur_hi", hi, 3);
      chk("load7_cur_ack", ak, 0);
      chk("load7_ready", int'(duty_if.duty_ready), 0);
      run_period(-1, 1'b1, 1'b0, 0, hi, ak);
      chk("load7_nxt_hi", hi, 7);
      chk("load7_ack", ak, 1);

      // load accepted in a boundary cycle waits one more period
      run_period(0, 1'b1, 1'b1, 5, hi, ak);
      chk("bnd_load_hi", hi, 7);
      run_period(-1, 1'b1, 1'b0, 0, hi, ak);
      chk("bnd_load_hi2", hi, 5);

      // stop at cnt=4, restart at cnt=2
      run_period(4, 1'b0, 1'b0, 0, hi, ak);
      chk("drain_hi", hi, 5);
      run_period(2, 1'b1, 1'b0, 0, hi, ak);
      chk("idle_armed_hi", hi, 0);
      chk("armed_running", int'(running), 0);
      run_period(-1, 1'b1, 1'b0, 0, hi, ak);
      chk("restart_hi", hi, 5);

      // duty 0 and duty 256
      run_period(1, 1'b1, 1'b1, 0, hi, ak);
      chk("pre0_hi", hi, 5);
      run_period(-1, 1'b1, 1'b0, 0, hi, ak);
      chk("duty0_hi", hi, 0);
      run_period(1, 1'b1, 1'b1, 256, hi, ak);
      chk("pre256_hi", hi, 0);
      run_period(-1, 1'b1, 1'b0, 0, hi, ak);
      chk("duty256_hi", hi, 10);

      // stalled counter with held rollover: nothing may move
      sync();
      cen    = 1'b0;
      pwm_en = 1'b0;
      duty_if.duty_valid = 1'b1;
      duty_if.duty_data  = 9'd4;
      ak = 0;
      for (int i = 0; i < 21; i++) begin
         step();
         ak += int'(update_ack);
      end
      chk("stall_ack", ak, 0);
      chk("stall_running", int'(running), 1);
      chk("stall_ready", int'(duty_if.duty_ready), 0);
      chk("stall_pwm", int'(pwm_out), 1);
      cen    = 1'b1;
      pwm_en = 1'b1;
      step();
      sync();
      run_period(-1, 1'b1, 1'b0, 0, hi, ak);
      chk("post_stall_hi", hi, 4);
      chk("post_stall_ack", ak, 1);

      // async reset mid-RUN with a pending load
      for (int i = 0; i < 3; i++) step();
      duty_if.duty_valid = 1'b1;
      duty_if.duty_data  = 9'd9;
      step();
      chk("pre_rst_pwm", int'(pwm_out), 1);
      reset_n = 1'b0;
      #1;
      chk("arst_pwm", int'(pwm_out), 0);
      chk("arst_running", int'(running), 0);
      chk("arst_ready", int'(duty_if.duty_ready), 1);
      chk("arst_ack", int'(update_ack), 0);
      model_reset();
      @(posedge clk);
      #1;
      cnt_advance();
      reset_n = 1'b1;
      step();
      sync();
      run_period(-1, 1'b1, 1'b0, 0, hi, ak);
      chk("after_rst_hi", hi, 0);
      run_period(-1, 1'b1, 1'b0, 0, hi, ak);
      chk("after_rst_hi2", hi, 0);
      chk("after_rst_ack", ak, 0);

      chk("sb_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
